// File: rtl/ifetch_dram_responder_if.sv
// ifetch_dram_responder_if: read channel between the fetch responder
// and the 64-bit instruction backing memory.
interface ifetch_dram_responder_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ifetch_dram_responder.sv
// ifetch_dram_responder: DRAM fetch channel responder for the IF2 stage.
// Optional single-line buffer enabled by defining IFETCH_LINE_BUF_EN.
module ifetch_dram_responder #(
  parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [63:0] fetch_addr,
  input  logic        flush,
  input  logic        inv,
  output logic        if_channel_sel,
  output logic [31:0] dram_dout,
  output logic        dram_data_ready,
  output logic        fetch_busy,
  ifetch_dram_responder_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:2] addr_q;
  logic        accept;
  logic        hit;
  logic        fill;
  logic [31:0] hit_word;
  logic [31:0] ack_word;
  logic        unused_ok;

  assign if_channel_sel = fetch_addr >= DRAM_BASE;
  assign accept = (state == IDLE) && fetch_req
                  && if_channel_sel && !flush;
  assign fill = mem.mem_ack
                && (state == REQ || state == DRAIN);
  assign ack_word = addr_q[2] ? mem.mem_rdata[63:32]
                              : mem.mem_rdata[31:0];

  // addr_q only changes on accept, so mem_addr stays stable in REQ/DRAIN
  assign mem.mem_addr = {addr_q[63:3], 3'b000};

`ifdef IFETCH_LINE_BUF_EN
  logic        buf_vld;
  logic [63:3] buf_tag;
  logic [63:0] buf_data;

  // invalidate wins over a same-cycle lookup or fill
  assign hit = buf_vld && !inv
               && (buf_tag == fetch_addr[63:3]);
  assign hit_word = fetch_addr[2] ? buf_data[63:32]
                                  : buf_data[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld <= 1'b0;
    end else if (inv) begin
      buf_vld <= 1'b0;
    end else if (fill) begin
      buf_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      buf_tag  <= addr_q[63:3];
      buf_data <= mem.mem_rdata;
    end
  end

  assign unused_ok = &{1'b0, fetch_addr[1:0]};
`else
  assign hit = 1'b0;
  assign hit_word = '0;
  assign unused_ok = &{1'b0, fetch_addr[1:0], inv};
`endif

  always_comb begin
    state_nx   = state;
    fetch_busy = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          fetch_busy = 1'b1;
          state_nx   = hit ? RESP : REQ;
        end
      end
      REQ: begin
        fetch_busy = 1'b1;
        if (mem.mem_ack) begin
          state_nx = flush ? IDLE : RESP;
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        fetch_busy = 1'b1;
        if (mem.mem_ack) begin
          state_nx = IDLE;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      mem.mem_req     <= 1'b0;
      dram_dout       <= '0;
      dram_data_ready <= 1'b0;
    end else begin
      state           <= state_nx;
      dram_data_ready <= (state_nx == RESP);
      mem.mem_req     <= (state_nx == REQ)
                         || (state_nx == DRAIN);
      if (accept) begin
        addr_q <= fetch_addr[63:2];
      end
      if (accept && hit) begin
        dram_dout <= hit_word;
      end else if (state == REQ && mem.mem_ack
                   && !flush) begin
        dram_dout <= ack_word;
      end
    end
  end

endmodule
